// File: rtl/target_tx_if.sv
// -----------------------------------------------------------------------------
// target_tx_if
// Groups the handshake and data signals of the HDR-DDR target transmit
// serializer into one bundle.
//   master : the side that drives the serializer (DDR/CCC engine, register
//            file, CRC block, SCL generator).
//   slave  : the serializer itself (target_tx).
// Signals:
//   i_sclgen_scl_pos_edge / i_sclgen_scl_neg_edge : one-clock SCL edge pulses
//   i_ddrccc_tx_en / i_ddrccc_tx_mode             : mode handshake request
//   i_ddrccc_preamble                             : 2-bit preamble value
//   i_regf_tx_data                                : byte to transmit
//   i_crc_value                                   : CRC-5 to transmit
//   o_sdahnd_tx_sda / o_sdahnd_tx_oe              : serial data and drive enable
//   o_ddrccc_tx_mode_done                         : mode-complete pulse
//   o_crc_byte / o_crc_byte_valid                 : byte handed to the CRC block
// -----------------------------------------------------------------------------
interface target_tx_if;
    logic       i_sclgen_scl_pos_edge;
    logic       i_sclgen_scl_neg_edge;
    logic       i_ddrccc_tx_en;
    logic [3:0] i_ddrccc_tx_mode;
    logic [1:0] i_ddrccc_preamble;
    logic [7:0] i_regf_tx_data;
    logic [4:0] i_crc_value;
    logic       o_sdahnd_tx_sda;
    logic       o_sdahnd_tx_oe;
    logic       o_ddrccc_tx_mode_done;
    logic [7:0] o_crc_byte;
    logic       o_crc_byte_valid;

    modport master (
        output i_sclgen_scl_pos_edge,
        output i_sclgen_scl_neg_edge,
        output i_ddrccc_tx_en,
        output i_ddrccc_tx_mode,
        output i_ddrccc_preamble,
        output i_regf_tx_data,
        output i_crc_value,
        input  o_sdahnd_tx_sda,
        input  o_sdahnd_tx_oe,
        input  o_ddrccc_tx_mode_done,
        input  o_crc_byte,
        input  o_crc_byte_valid
    );

    modport slave (
        input  i_sclgen_scl_pos_edge,
        input  i_sclgen_scl_neg_edge,
        input  i_ddrccc_tx_en,
        input  i_ddrccc_tx_mode,
        input  i_ddrccc_preamble,
        input  i_regf_tx_data,
        input  i_crc_value,
        output o_sdahnd_tx_sda,
        output o_sdahnd_tx_oe,
        output o_ddrccc_tx_mode_done,
        output o_crc_byte,
        output o_crc_byte_valid
    );
endinterface

// File: rtl/target_tx.sv
// -----------------------------------------------------------------------------
// target_tx
// HDR-DDR target-side serializer. On accept (en=1 while idle) it loads the
// pattern selected by the mode MSB-first into a shift register and then
// presents one bit per SCL edge (rise or fall) on SDA. Modes:
//   0 preamble (2b), 1 first byte (8b, kept in D1), 2 second byte (8b, kept
//   in D2), 3 word parity (2b, from {D1,D2}), 4 CRC token (4b), 5 CRC value
//   (5b), 6..15 illegal (no bits, immediate done).
// Ports:
//   i_sys_clk : system clock
//   i_sys_rst : synchronous active-high reset
//   bus       : target_tx_if.slave bundle (edges, handshake, data, SDA, CRC)
// -----------------------------------------------------------------------------
module target_tx #(
    parameter logic [3:0] TOKEN_CRC = 4'b1100,
    parameter logic       SDA_IDLE  = 1'b1
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    target_tx_if.slave bus
);

    localparam logic [3:0] MODE_PREAMBLE    = 4'd0;
    localparam logic [3:0] MODE_FIRST_BYTE  = 4'd1;
    localparam logic [3:0] MODE_SECOND_BYTE = 4'd2;
    localparam logic [3:0] MODE_PARITY      = 4'd3;
    localparam logic [3:0] MODE_TOKEN_CRC   = 4'd4;
    localparam logic [3:0] MODE_CRC_VALUE   = 4'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sda_q, sda_d;
    logic       oe_q, oe_d;
    logic       done_q, done_d;
    logic [7:0] crc_byte_q, crc_byte_d;
    logic       crc_byte_valid_q, crc_byte_valid_d;
    logic [7:0] d1_q, d1_d;
    logic [7:0] d2_q, d2_d;

    // Simultaneous rise and fall pulses collapse into a single edge.
    logic scl_edge;
    assign scl_edge = bus.i_sclgen_scl_pos_edge | bus.i_sclgen_scl_neg_edge;

    // ------------------------------------------------------------------
    // Word parity over W = {D1, D2}: PA1 covers odd bit positions,
    // PA0 covers even positions and is inverted.
    // ------------------------------------------------------------------
    logic [15:0] word;
    logic [7:0]  odd_bits;
    logic [7:0]  even_bits;
    logic        pa1;
    logic        pa0;

    assign word = {d1_q, d2_q};

    for (genvar gi = 0; gi < 8; gi++) begin : g_parity_split
        assign odd_bits[gi]  = word[2*gi+1];
        assign even_bits[gi] = word[2*gi];
    end

    assign pa1 = ^odd_bits;
    assign pa0 = ~(^even_bits);

    // ------------------------------------------------------------------
    // Pattern to load on accept, MSB-aligned, with index of its last bit.
    // ------------------------------------------------------------------
    logic [7:0] load_pattern;
    logic [2:0] load_last;
    logic       load_legal;

    always_comb begin
        load_pattern = 8'h00;
        load_last    = 3'd0;
        load_legal   = 1'b1;
        case (bus.i_ddrccc_tx_mode)
            MODE_PREAMBLE: begin
                load_pattern = {bus.i_ddrccc_preamble, 6'b0};
                load_last    = 3'd1;
            end
            MODE_FIRST_BYTE, MODE_SECOND_BYTE: begin
                load_pattern = bus.i_regf_tx_data;
                load_last    = 3'd7;
            end
            MODE_PARITY: begin
                load_pattern = {pa1, pa0, 6'b0};
                load_last    = 3'd1;
            end
            MODE_TOKEN_CRC: begin
                load_pattern = {TOKEN_CRC, 4'b0};
                load_last    = 3'd3;
            end
            MODE_CRC_VALUE: begin
                load_pattern = {bus.i_crc_value, 3'b0};
                load_last    = 3'd4;
            end
            default: begin
                load_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q          <= ST_IDLE;
            shift_q          <= 8'h00;
            bit_cnt_q        <= 3'd0;
            sda_q            <= SDA_IDLE;
            oe_q             <= 1'b0;
            done_q           <= 1'b0;
            crc_byte_q       <= 8'h00;
            crc_byte_valid_q <= 1'b0;
            d1_q             <= 8'h00;
            d2_q             <= 8'h00;
        end else begin
            state_q          <= state_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            sda_q            <= sda_d;
            oe_q             <= oe_d;
            done_q           <= done_d;
            crc_byte_q       <= crc_byte_d;
            crc_byte_valid_q <= crc_byte_valid_d;
            d1_q             <= d1_d;
            d2_q             <= d2_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Illegal modes never enter SHIFT: their done pulse
    // is raised directly at accept, so they consume no SCL edges.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_ddrccc_tx_en && load_legal) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!bus.i_ddrccc_tx_en) begin
                    state_d = ST_IDLE;
                end else if (scl_edge && (bit_cnt_q == 3'd0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values.
    // The current bit lives in shift_q[7] and is mirrored in sda_q, so the
    // next bit to present is always shift_q[6].
    // ------------------------------------------------------------------
    always_comb begin
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        sda_d            = sda_q;
        oe_d             = oe_q;
        done_d           = 1'b0;
        crc_byte_d       = crc_byte_q;
        crc_byte_valid_d = 1'b0;
        d1_d             = d1_q;
        d2_d             = d2_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_ddrccc_tx_en) begin
                    if (load_legal) begin
                        shift_d   = load_pattern;
                        bit_cnt_d = load_last;
                        sda_d     = load_pattern[7];
                        oe_d      = 1'b1;
                    end else begin
                        // Illegal mode: complete at once, leave SDA/OE alone.
                        done_d = 1'b1;
                    end
                    if (bus.i_ddrccc_tx_mode == MODE_FIRST_BYTE) begin
                        d1_d             = bus.i_regf_tx_data;
                        crc_byte_d       = bus.i_regf_tx_data;
                        crc_byte_valid_d = 1'b1;
                    end
                    if (bus.i_ddrccc_tx_mode == MODE_SECOND_BYTE) begin
                        d2_d             = bus.i_regf_tx_data;
                        crc_byte_d       = bus.i_regf_tx_data;
                        crc_byte_valid_d = 1'b1;
                    end
                end else begin
                    oe_d  = 1'b0;
                    sda_d = SDA_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.i_ddrccc_tx_en) begin
                    // Abort: release the line without signalling completion.
                    oe_d  = 1'b0;
                    sda_d = SDA_IDLE;
                end else if (scl_edge) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_d     = shift_q[6];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        // Last bit stays on SDA through the done clock.
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.o_sdahnd_tx_sda       = sda_q;
    assign bus.o_sdahnd_tx_oe        = oe_q;
    assign bus.o_ddrccc_tx_mode_done = done_q;
    assign bus.o_crc_byte            = crc_byte_q;
    assign bus.o_crc_byte_valid      = crc_byte_valid_q;

endmodule

// File: tb/tb_target_tx.sv
// -----------------------------------------------------------------------------
// tb_target_tx
// Self-checking bench for target_tx: a table of known mode vectors run
// back-to-back, hand-written reset/abort/illegal-mode sequences, and a
// randomized run checked against a bit-list reference model.
// -----------------------------------------------------------------------------
module tb_target_tx;

    logic clk;
    logic srst;

    target_tx_if bus ();

    target_tx dut (
        .i_sys_clk (clk),
        .i_sys_rst (srst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks_total;
    int checks_passed;

    // Reference copies of the stored bytes D1/D2.
    logic [7:0] m_d1;
    logic [7:0] m_d2;

    typedef struct {
        logic [3:0] mode;
        logic [7:0] data;
        logic [1:0] pre;
        logic [4:0] crc;
        int         len;
        logic [7:0] bits;   // expected serial bits, MSB first
        bit         is_byte;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SCL edge: rise, fall or both in the same clock.
    task automatic edge_tick();
        int r;
        r = $urandom_range(0, 2);
        bus.i_sclgen_scl_pos_edge = (r != 1);
        bus.i_sclgen_scl_neg_edge = (r != 0);
        tick();
        bus.i_sclgen_scl_pos_edge = 1'b0;
        bus.i_sclgen_scl_neg_edge = 1'b0;
    endtask

    // Bit list of a mode, straight from the mode rules.
    task automatic model_bits(input logic [3:0] mode, input logic [7:0] data,
                              input logic [1:0] pre, input logic [4:0] crc,
                              output int len, output logic [7:0] bits);
        logic [15:0] w;
        logic p1;
        logic p0;
        bits = 8'h00;
        len  = 0;
        case (mode)
            4'd0: begin len = 2; bits = {pre, 6'b0}; end
            4'd1, 4'd2: begin len = 8; bits = data; end
            4'd3: begin
                w  = {m_d1, m_d2};
                p1 = 1'b0;
                p0 = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (i % 2 == 1) p1 = p1 ^ w[i];
                    else            p0 = p0 ^ w[i];
                end
                len  = 2;
                bits = {p1, p0, 6'b0};
            end
            4'd4: begin len = 4; bits = 8'b1100_0000; end
            4'd5: begin len = 5; bits = {crc, 3'b0}; end
            default: begin len = 0; end
        endcase
    endtask

    // Accept one mode, then feed its edges with random gaps. Returns in the
    // done clock with en still 1, or (abort_after>0) after dropping en.
    task automatic run_mode(input logic [3:0] mode, input logic [7:0] data,
                            input logic [1:0] pre, input logic [4:0] crc,
                            input int len, input logic [7:0] bits,
                            input bit is_byte, input int abort_after);
        int gaps;
        bus.i_ddrccc_tx_en    = 1'b1;
        bus.i_ddrccc_tx_mode  = mode;
        bus.i_regf_tx_data    = data;
        bus.i_ddrccc_preamble = pre;
        bus.i_crc_value       = crc;
        tick();
        if (mode == 4'd1) m_d1 = data;
        if (mode == 4'd2) m_d2 = data;
        check("accept_oe", bus.o_sdahnd_tx_oe, 1);
        check("accept_sda", bus.o_sdahnd_tx_sda, bits[7]);
        check("accept_done", bus.o_ddrccc_tx_mode_done, 0);
        check("crc_valid", bus.o_crc_byte_valid, is_byte);
        if (is_byte) check("crc_byte", bus.o_crc_byte, data);
        // Inputs are only sampled at accept; scramble them afterwards.
        bus.i_ddrccc_tx_mode  = 4'($urandom);
        bus.i_regf_tx_data    = 8'($urandom);
        bus.i_ddrccc_preamble = 2'($urandom);
        bus.i_crc_value       = 5'($urandom);
        for (int i = 1; i <= len; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                tick();
                check("hold_sda", bus.o_sdahnd_tx_sda, bits[8-i]);
                check("hold_done", bus.o_ddrccc_tx_mode_done, 0);
            end
            edge_tick();
            check("valid_drop", bus.o_crc_byte_valid, 0);
            if (i < len) begin
                check("bit_sda", bus.o_sdahnd_tx_sda, bits[7-i]);
                check("bit_done", bus.o_ddrccc_tx_mode_done, 0);
            end else begin
                check("done_pulse", bus.o_ddrccc_tx_mode_done, 1);
                check("last_sda", bus.o_sdahnd_tx_sda, bits[8-len]);
                check("done_oe", bus.o_sdahnd_tx_oe, 1);
            end
            if (i == abort_after) begin
                bus.i_ddrccc_tx_en = 1'b0;
                tick();
                check("abort_oe", bus.o_sdahnd_tx_oe, 0);
                check("abort_sda", bus.o_sdahnd_tx_sda, 1);
                check("abort_done", bus.o_ddrccc_tx_mode_done, 0);
                return;
            end
        end
    endtask

    task automatic release_line();
        bus.i_ddrccc_tx_en = 1'b0;
        tick();
        check("release_oe", bus.o_sdahnd_tx_oe, 0);
        check("release_sda", bus.o_sdahnd_tx_sda, 1);
        check("release_done", bus.o_ddrccc_tx_mode_done, 0);
    endtask

    initial begin
        int         len;
        logic [7:0] bits;
        logic [3:0] mode;
        logic [7:0] data;
        logic [1:0] pre;
        logic [4:0] crc;
        int         abort;

        checks_total  = 0;
        checks_passed = 0;
        m_d1 = 8'h00;
        m_d2 = 8'h00;

        // Parity entries: A5/BD gives PA1=1, PA0=0; 00/00 gives PA1=0, PA0=1.
        vecs[0] = '{4'd0, 8'h00, 2'b01, 5'd0,     2, 8'h40, 1'b0};
        vecs[1] = '{4'd1, 8'hA5, 2'b00, 5'd0,     8, 8'hA5, 1'b1};
        vecs[2] = '{4'd2, 8'hBD, 2'b00, 5'd0,     8, 8'hBD, 1'b1};
        vecs[3] = '{4'd3, 8'h00, 2'b00, 5'd0,     2, 8'h80, 1'b0};
        vecs[4] = '{4'd1, 8'h00, 2'b00, 5'd0,     8, 8'h00, 1'b1};
        vecs[5] = '{4'd2, 8'h00, 2'b00, 5'd0,     8, 8'h00, 1'b1};
        vecs[6] = '{4'd3, 8'hFF, 2'b00, 5'd0,     2, 8'h40, 1'b0};
        vecs[7] = '{4'd4, 8'h00, 2'b00, 5'd0,     4, 8'hC0, 1'b0};
        vecs[8] = '{4'd5, 8'h00, 2'b00, 5'b11100, 5, 8'hE0, 1'b0};
        vecs[9] = '{4'd0, 8'h00, 2'b10, 5'd0,     2, 8'h80, 1'b0};

        srst = 1'b1;
        bus.i_sclgen_scl_pos_edge = 1'b0;
        bus.i_sclgen_scl_neg_edge = 1'b0;
        bus.i_ddrccc_tx_en        = 1'b0;
        bus.i_ddrccc_tx_mode      = 4'd0;
        bus.i_ddrccc_preamble     = 2'b00;
        bus.i_regf_tx_data        = 8'h00;
        bus.i_crc_value           = 5'd0;
        tick();
        tick();
        check("rst_sda", bus.o_sdahnd_tx_sda, 1);
        check("rst_oe", bus.o_sdahnd_tx_oe, 0);
        check("rst_done", bus.o_ddrccc_tx_mode_done, 0);
        check("rst_crc_byte", bus.o_crc_byte, 0);
        check("rst_crc_valid", bus.o_crc_byte_valid, 0);

        // Reset held while the engine requests a byte and SCL toggles.
        bus.i_ddrccc_tx_en   = 1'b1;
        bus.i_ddrccc_tx_mode = 4'd1;
        bus.i_regf_tx_data   = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            edge_tick();
            check("rsthold_sda", bus.o_sdahnd_tx_sda, 1);
            check("rsthold_oe", bus.o_sdahnd_tx_oe, 0);
            check("rsthold_done", bus.o_ddrccc_tx_mode_done, 0);
            check("rsthold_valid", bus.o_crc_byte_valid, 0);
        end
        bus.i_ddrccc_tx_en = 1'b0;
        srst = 1'b0;
        tick();

        // SCL edges in idle must not disturb anything.
        for (int k = 0; k < 3; k++) begin
            edge_tick();
            check("idle_sda", bus.o_sdahnd_tx_sda, 1);
            check("idle_oe", bus.o_sdahnd_tx_oe, 0);
            check("idle_done", bus.o_ddrccc_tx_mode_done, 0);
        end

        // Table: all vectors back-to-back with en held high.
        for (int v = 0; v < 10; v++) begin
            run_mode(vecs[v].mode, vecs[v].data, vecs[v].pre, vecs[v].crc,
                     vecs[v].len, vecs[v].bits, vecs[v].is_byte, 0);
        end
        release_line();

        // Abort after 3 edges of a first byte.
        run_mode(4'd1, 8'h3C, 2'b00, 5'd0, 8, 8'h3C, 1'b1, 3);
        tick();
        check("abort_nodone", bus.o_ddrccc_tx_mode_done, 0);
        check("abort_idle_oe", bus.o_sdahnd_tx_oe, 0);

        // Reset in the middle of a CRC value.
        bus.i_ddrccc_tx_en   = 1'b1;
        bus.i_ddrccc_tx_mode = 4'd5;
        bus.i_crc_value      = 5'b10110;
        tick();
        check("m5_bit0", bus.o_sdahnd_tx_sda, 1);
        edge_tick();
        check("m5_bit1", bus.o_sdahnd_tx_sda, 0);
        edge_tick();
        check("m5_bit2", bus.o_sdahnd_tx_sda, 1);
        srst = 1'b1;
        tick();
        m_d1 = 8'h00;
        m_d2 = 8'h00;
        check("midrst_sda", bus.o_sdahnd_tx_sda, 1);
        check("midrst_oe", bus.o_sdahnd_tx_oe, 0);
        check("midrst_done", bus.o_ddrccc_tx_mode_done, 0);
        check("midrst_crc_byte", bus.o_crc_byte, 0);
        check("midrst_valid", bus.o_crc_byte_valid, 0);
        srst = 1'b0;
        bus.i_ddrccc_tx_en = 1'b0;
        tick();

        // Parity right after reset uses the cleared bytes.
        run_mode(4'd3, 8'h00, 2'b00, 5'd0, 2, 8'h40, 1'b0, 0);
        release_line();

        // Illegal mode from idle: done next clock, no drive.
        bus.i_ddrccc_tx_en   = 1'b1;
        bus.i_ddrccc_tx_mode = 4'hA;
        tick();
        check("ill_done", bus.o_ddrccc_tx_mode_done, 1);
        check("ill_oe", bus.o_sdahnd_tx_oe, 0);
        check("ill_sda", bus.o_sdahnd_tx_sda, 1);
        check("ill_valid", bus.o_crc_byte_valid, 0);
        release_line();

        // Illegal mode following a token: oe and last bit are kept, and the
        // next legal mode starts straight away.
        run_mode(4'd4, 8'h00, 2'b00, 5'd0, 4, 8'hC0, 1'b0, 0);
        bus.i_ddrccc_tx_mode = 4'hA;
        tick();
        check("ill2_done", bus.o_ddrccc_tx_mode_done, 1);
        check("ill2_oe", bus.o_sdahnd_tx_oe, 1);
        check("ill2_sda", bus.o_sdahnd_tx_sda, 0);
        run_mode(4'd0, 8'h00, 2'b11, 5'd0, 2, 8'hC0, 1'b0, 0);
        release_line();

        // Randomized modes against the reference model.
        for (int n = 0; n < 40; n++) begin
            mode = 4'($urandom_range(0, 5));
            data = 8'($urandom);
            pre  = 2'($urandom);
            crc  = 5'($urandom);
            model_bits(mode, data, pre, crc, len, bits);
            abort = 0;
            if (len > 1 && $urandom_range(0, 5) == 0) abort = $urandom_range(1, len - 1);
            run_mode(mode, data, pre, crc, len, bits, (mode == 4'd1 || mode == 4'd2), abort);
            if (abort == 0 && $urandom_range(0, 1) == 0) release_line();
        end
        release_line();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
